// File: rtl/usb_buf_mem_pkg.sv
// ============================================================================
// Module      : usb_buf_mem_pkg
// Description : Shared widths, bus FSM encoding and counter width for the
//               usb_buf_mem packet buffer (optional USB_BUF_MEM_COLLISION_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_buf_mem_pkg;

    localparam int COLL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_PIPE = 2'd2,
        ST_RESP = 2'd3
    } bus_state_t;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    function automatic int strb_w(input int bus_w);
        return bus_w / 8;
    endfunction

    function automatic int byte_aw(input int ch_bytes, input int channels);
        return clog2(ch_bytes * channels);
    endfunction

    function automatic int word_aw(input int bus_w, input int ch_bytes, input int channels);
        return byte_aw(ch_bytes, channels) - clog2(bus_w / 8);
    endfunction

    // A single-channel build still carries a 1-bit channel select port.
    function automatic int chan_w(input int channels);
        return (channels > 1) ? clog2(channels) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_buf_mem_if.sv
// ============================================================================
// Module      : usb_buf_mem_if
// Description : CPU-side request/response bus of the usb_buf_mem buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface usb_buf_mem_if
    import usb_buf_mem_pkg::*;
#(
    parameter int BUS_W = 32,
    parameter int AW    = 9
);
    localparam int STRB_W = strb_w(BUS_W);

    logic              avalid;
    logic              aready;
    logic              awe;
    logic [AW-1:0]     aaddr;
    logic [BUS_W-1:0]  adata;
    logic [STRB_W-1:0] astrb;
    logic              bvalid;
    logic              bready;
    logic [BUS_W-1:0]  bdata;

    modport master (
        output avalid, awe, aaddr, adata, astrb, bready,
        input  aready, bvalid, bdata
    );

    modport slave (
        input  avalid, awe, aaddr, adata, astrb, bready,
        output aready, bvalid, bdata
    );

endinterface

`default_nettype wire

// File: rtl/usb_buf_dpram.sv
// ============================================================================
// Module      : usb_buf_dpram
// Description : True dual-port read-first RAM; port A is BUS_W wide with byte
//               enables, port B is byte wide. Little-endian byte lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_buf_dpram
    import usb_buf_mem_pkg::*;
#(
    parameter int BUS_W   = 32,
    parameter int BYTE_AW = 11
) (
    input  wire logic                                    clk,
    input  wire logic                                    rst_n,
    input  wire logic                                    a_re_i,
    input  wire logic [BUS_W/8-1:0]                      a_we_i,
    input  wire logic [BYTE_AW-clog2(BUS_W/8)-1:0]       a_addr_i,
    input  wire logic [BUS_W-1:0]                        a_din_i,
    output logic      [BUS_W-1:0]                        a_dout_o,
    input  wire logic                                    b_re_i,
    input  wire logic                                    b_we_i,
    input  wire logic [BYTE_AW-1:0]                      b_addr_i,
    input  wire logic [7:0]                              b_din_i,
    output logic      [7:0]                              b_dout_o
);
    localparam int STRB_W  = strb_w(BUS_W);
    localparam int LANE_W  = clog2(STRB_W);
    localparam int WORD_AW = BYTE_AW - LANE_W;
    localparam int DEPTH   = 1 << WORD_AW;

    logic [STRB_W-1:0][7:0] mem_q [DEPTH];

    logic [WORD_AW-1:0] w_b_word;
    logic [LANE_W-1:0]  w_b_lane;

    assign w_b_word = b_addr_i[BYTE_AW-1:LANE_W];
    assign w_b_lane = b_addr_i[LANE_W-1:0];

    // Port B is applied after port A so it owns a same-byte collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (a_we_i[i]) begin
                mem_q[a_addr_i][i] <= a_din_i[8*i +: 8];
            end
        end
        if (b_we_i) begin
            mem_q[w_b_word][w_b_lane] <= b_din_i;
        end
    end

    // Reads sample the array before this edge's writes land (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout_o <= '0;
            b_dout_o <= '0;
        end else begin
            if (a_re_i) begin
                a_dout_o <= mem_q[a_addr_i];
            end
            if (b_re_i) begin
                b_dout_o <= mem_q[w_b_word][w_b_lane];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/usb_buf_mem.sv
// ============================================================================
// Module      : usb_buf_mem
// Description : Dual-port USB packet buffer: CPU request/response bus on one
//               side, auto-incrementing byte port on the other.
//               Optional collision counter: USB_BUF_MEM_COLLISION_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_buf_mem
    import usb_buf_mem_pkg::*;
#(
    parameter int BUS_W    = 32,
    parameter int CH_BYTES = 1024,
    parameter int CHANNELS = 2,
    parameter int RD_PIPE  = 0
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    usb_buf_mem_if.slave                       bus,
    input  wire logic [chan_w(CHANNELS)-1:0]   mem_chan,
    input  wire logic                          mem_load,
    input  wire logic [clog2(CH_BYTES)-1:0]    mem_addr,
    input  wire logic                          mem_we,
    input  wire logic                          mem_re,
    input  wire logic [7:0]                    mem_write_data,
`ifdef USB_BUF_MEM_COLLISION_CNT_EN
    output logic      [COLL_CNT_W-1:0]         coll_cnt,
`endif
    output logic      [7:0]                    mem_read_data,
    output logic                               mem_rvalid,
    output logic      [clog2(CH_BYTES)-1:0]    mem_ptr
);
    localparam int STRB_W = strb_w(BUS_W);
    localparam int LANE_W = clog2(STRB_W);
    localparam int WAW    = word_aw(BUS_W, CH_BYTES, CHANNELS);
    localparam int BAW    = byte_aw(CH_BYTES, CHANNELS);
    localparam int PTR_W  = clog2(CH_BYTES);

    bus_state_t        state_q, state_d;
    logic              req_we_q;
    logic [WAW-1:0]    req_addr_q;
    logic [BUS_W-1:0]  req_data_q;
    logic [STRB_W-1:0] req_strb_q;
    logic [BUS_W-1:0]  bdata_q;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              rvalid_q;

    logic              w_accept;
    logic              w_access;
    logic [PTR_W-1:0]  w_ptr_eff;
    logic [BAW-1:0]    w_baddr;
    logic [WAW-1:0]    w_a_addr;
    logic [STRB_W-1:0] w_a_we;
    logic [BUS_W-1:0]  w_ram_dout;
    logic [BUS_W-1:0]  w_rdata;
    logic              w_bdata_load;
    logic [BUS_W-1:0]  w_bdata_src;
    logic              w_top_wr;

    assign w_accept   = (state_q == ST_IDLE) && bus.avalid;
    assign bus.aready = (state_q == ST_IDLE);
    assign bus.bvalid = (state_q == ST_RESP);
    assign bus.bdata  = bdata_q;

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.avalid) state_d = ST_ACC;
            ST_ACC:  state_d = (RD_PIPE != 0) ? ST_PIPE : ST_RESP;
            ST_PIPE: state_d = ST_RESP;
            ST_RESP: if (bus.bready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_strb_q <= '0;
            bdata_q    <= '0;
        end else begin
            if (w_accept) begin
                req_we_q   <= bus.awe;
                req_addr_q <= bus.aaddr;
                req_data_q <= bus.adata;
                req_strb_q <= bus.astrb;
            end
            if (w_bdata_load) begin
                bdata_q <= w_bdata_src;
            end
        end
    end

    // The read is issued from the live request on acceptance; the write
    // lands one cycle later in ACC, so a write response carries the old word.
    assign w_a_addr = (state_q == ST_IDLE) ? bus.aaddr : req_addr_q;
    assign w_top_wr = (state_q == ST_ACC) && req_we_q;

    generate
        if (RD_PIPE != 0) begin : g_rd_pipe
            logic [BUS_W-1:0] pipe_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_q <= '0;
                end else if (state_q == ST_ACC) begin
                    pipe_q <= w_rdata;
                end
            end
            assign w_bdata_load = (state_q == ST_PIPE);
            assign w_bdata_src  = pipe_q;
        end else begin : g_rd_direct
            assign w_bdata_load = (state_q == ST_ACC);
            assign w_bdata_src  = w_rdata;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Byte port pointer
    // ------------------------------------------------------------------
    assign w_access  = mem_we || mem_re;
    assign w_ptr_eff = mem_load ? mem_addr : ptr_q;

    generate
        if (CHANNELS > 1) begin : g_multi_ch
            assign w_baddr = {mem_chan, w_ptr_eff};
        end else begin : g_single_ch
            assign w_baddr = w_ptr_eff;
        end
    endgenerate

    always_comb begin
        ptr_d = ptr_q;
        if (mem_load) begin
            ptr_d = w_access ? (mem_addr + PTR_W'(1)) : mem_addr;
        end else if (w_access) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= mem_re;
        end
    end

    assign mem_ptr    = ptr_q;
    assign mem_rvalid = rvalid_q;

    // ------------------------------------------------------------------
    // Collision counter living in the top word of the bus address space
    // ------------------------------------------------------------------
`ifdef USB_BUF_MEM_COLLISION_CNT_EN
    logic                  top_q;
    logic [COLL_CNT_W-1:0] coll_cnt_q;
    logic                  w_coll_hit;

    assign w_coll_hit = w_top_wr && !top_q && mem_we &&
                        (w_baddr[BAW-1:LANE_W] == req_addr_q) &&
                        req_strb_q[w_baddr[LANE_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q      <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            if (w_accept) begin
                top_q <= (bus.aaddr == {WAW{1'b1}});
            end
            if (w_top_wr && top_q) begin
                coll_cnt_q <= '0;
            end else if (w_coll_hit && (coll_cnt_q != {COLL_CNT_W{1'b1}})) begin
                coll_cnt_q <= coll_cnt_q + COLL_CNT_W'(1);
            end
        end
    end

    assign coll_cnt = coll_cnt_q;
    assign w_a_we   = (w_top_wr && !top_q) ? req_strb_q : '0;
    assign w_rdata  = top_q ? {{(BUS_W-COLL_CNT_W){1'b0}}, coll_cnt_q} : w_ram_dout;
`else
    assign w_a_we   = w_top_wr ? req_strb_q : '0;
    assign w_rdata  = w_ram_dout;
`endif

    usb_buf_dpram #(
        .BUS_W   (BUS_W),
        .BYTE_AW (BAW)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_re_i   (w_accept),
        .a_we_i   (w_a_we),
        .a_addr_i (w_a_addr),
        .a_din_i  (req_data_q),
        .a_dout_o (w_ram_dout),
        .b_re_i   (mem_re),
        .b_we_i   (mem_we),
        .b_addr_i (w_baddr),
        .b_din_i  (mem_write_data),
        .b_dout_o (mem_read_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_usb_buf_mem.sv
// ============================================================================
// Module      : tb_usb_buf_mem
// Description : Directed, table-driven bench for usb_buf_mem (default build and
//               a 64-bit RD_PIPE=1 instance). Honours USB_BUF_MEM_COLLISION_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_buf_mem;
    import usb_buf_mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [0:0]  mem_chan;
    logic        mem_load;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_write_data;
    logic [7:0]  rd_data0, rd_data1;
    logic        rvalid0, rvalid1;
    logic [9:0]  ptr0, ptr1;
`ifdef USB_BUF_MEM_COLLISION_CNT_EN
    logic [15:0] coll_cnt0, coll_cnt1;
    localparam logic [31:0] TOP_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] TOP_EXP = 32'h1100_0000;
`endif

    int n_checks = 0;
    int n_err    = 0;

    usb_buf_mem_if #(.BUS_W(32), .AW(9)) bif ();
    usb_buf_mem_if #(.BUS_W(64), .AW(8)) bifp ();

    usb_buf_mem #(.BUS_W(32), .CH_BYTES(1024), .CHANNELS(2), .RD_PIPE(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif),
        .mem_chan(mem_chan), .mem_load(mem_load), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_re(mem_re), .mem_write_data(mem_write_data),
`ifdef USB_BUF_MEM_COLLISION_CNT_EN
        .coll_cnt(coll_cnt0),
`endif
        .mem_read_data(rd_data0), .mem_rvalid(rvalid0), .mem_ptr(ptr0)
    );

    usb_buf_mem #(.BUS_W(64), .CH_BYTES(1024), .CHANNELS(2), .RD_PIPE(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .bus(bifp),
        .mem_chan(mem_chan), .mem_load(mem_load), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_re(mem_re), .mem_write_data(mem_write_data),
`ifdef USB_BUF_MEM_COLLISION_CNT_EN
        .coll_cnt(coll_cnt1),
`endif
        .mem_read_data(rd_data1), .mem_rvalid(rvalid1), .mem_ptr(ptr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vtab [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_xfer(input logic we, input logic [8:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rdata, output int lat);
        bif.avalid = 1'b1; bif.awe = we; bif.aaddr = addr;
        bif.adata = data; bif.astrb = strb; bif.bready = 1'b1;
        tick();
        bif.avalid = 1'b0;
        lat = 1;
        while (!bif.bvalid && lat < 20) begin
            tick();
            lat++;
        end
        rdata = bif.bdata;
        tick();
    endtask

    task automatic bus_xfer_p(input logic we, input logic [7:0] addr, input logic [63:0] data,
                              input logic [7:0] strb, output logic [63:0] rdata, output int lat);
        bifp.avalid = 1'b1; bifp.awe = we; bifp.aaddr = addr;
        bifp.adata = data; bifp.astrb = strb; bifp.bready = 1'b1;
        tick();
        bifp.avalid = 1'b0;
        lat = 1;
        while (!bifp.bvalid && lat < 20) begin
            tick();
            lat++;
        end
        rdata = bifp.bdata;
        tick();
    endtask

    task automatic byte_op(input logic load, input logic [9:0] addr, input logic we,
                           input logic re, input logic [7:0] wd);
        mem_load = load; mem_addr = addr; mem_we = we; mem_re = re; mem_write_data = wd;
        tick();
        mem_load = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
    endtask

    // Bus write whose ACC cycle coincides with a byte-port load+write.
    task automatic coll_write(input logic [8:0] waddr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [9:0] baddr,
                              input logic [7:0] bd, output logic [31:0] resp);
        int n;
        bif.avalid = 1'b1; bif.awe = 1'b1; bif.aaddr = waddr;
        bif.adata = wdata; bif.astrb = wstrb; bif.bready = 1'b1;
        tick();
        bif.avalid = 1'b0;
        mem_chan = 1'b0;
        byte_op(1'b1, baddr, 1'b1, 1'b0, bd);
        n = 2;
        while (!bif.bvalid && n < 20) begin
            tick();
            n++;
        end
        check("coll_lat", 64'(n), 64'd2);
        resp = bif.bdata;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [63:0] rdp;
        logic [7:0]  exp_b [4];
        int          lat;
        int          n;

        vtab[0]  = '{1'b1, 9'd0,   32'h0000_0000, 4'hF, 1'b0, 32'h0};
        vtab[1]  = '{1'b1, 9'd0,   32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0000_0000};
        vtab[2]  = '{1'b0, 9'd0,   32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF};
        vtab[3]  = '{1'b1, 9'd1,   32'h0000_0000, 4'hF, 1'b0, 32'h0};
        vtab[4]  = '{1'b1, 9'd1,   32'hAABB_CCDD, 4'h5, 1'b1, 32'h0000_0000};
        vtab[5]  = '{1'b0, 9'd1,   32'h0,         4'h0, 1'b1, 32'h00BB_00DD};
        vtab[6]  = '{1'b1, 9'd1,   32'h1122_3344, 4'h0, 1'b1, 32'h00BB_00DD};
        vtab[7]  = '{1'b0, 9'd1,   32'h0,         4'h0, 1'b1, 32'h00BB_00DD};
        vtab[8]  = '{1'b1, 9'd255, 32'h5A5A_5A5A, 4'hF, 1'b0, 32'h0};
        vtab[9]  = '{1'b1, 9'd256, 32'h0000_0000, 4'hF, 1'b0, 32'h0};
        vtab[10] = '{1'b1, 9'd511, 32'h0000_0000, 4'hF, 1'b0, 32'h0};
        vtab[11] = '{1'b0, 9'd511, 32'h0,         4'h0, 1'b1, TOP_EXP};
        vtab[12] = '{1'b0, 9'd256, 32'h0,         4'h0, 1'b1, 32'h0000_3322};
        vtab[13] = '{1'b0, 9'd255, 32'h0,         4'h0, 1'b1, 32'h5A5A_5A5A};
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;

        rst_n = 1'b0;
        mem_chan = 1'b0; mem_load = 1'b0; mem_addr = '0; mem_we = 1'b0;
        mem_re = 1'b0; mem_write_data = '0;
        bif.avalid = 1'b0; bif.awe = 1'b0; bif.aaddr = '0; bif.adata = '0;
        bif.astrb = '0; bif.bready = 1'b0;
        bifp.avalid = 1'b0; bifp.awe = 1'b0; bifp.aaddr = '0; bifp.adata = '0;
        bifp.astrb = '0; bifp.bready = 1'b0;
        repeat (3) tick();

        check("rst_aready", 64'(bif.aready), 64'd1);
        check("rst_bvalid", 64'(bif.bvalid), 64'd0);
        check("rst_bdata", 64'(bif.bdata), 64'd0);
        check("rst_rvalid", 64'(rvalid0), 64'd0);
        check("rst_rdata", 64'(rd_data0), 64'd0);
        check("rst_ptr", 64'(ptr0), 64'd0);
`ifdef USB_BUF_MEM_COLLISION_CNT_EN
        check("rst_coll_cnt", 64'(coll_cnt0), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i <= 10; i++) begin
            bus_xfer(vtab[i].we, vtab[i].addr, vtab[i].data, vtab[i].strb, rd, lat);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
            if (vtab[i].chk) check($sformatf("vec%0d_bdata", i), 64'(rd), 64'(vtab[i].exp));
        end

        // Channel 0 byte reads of the word written as 0xDEADBEEF.
        mem_chan = 1'b0;
        byte_op(1'b1, 10'd0, 1'b0, 1'b0, 8'h0);
        check("load_ptr", 64'(ptr0), 64'd0);
        for (int i = 0; i < 4; i++) begin
            byte_op(1'b0, 10'd0, 1'b0, 1'b1, 8'h0);
            check($sformatf("rd%0d_rvalid", i), 64'(rvalid0), 64'd1);
            check($sformatf("rd%0d_data", i), 64'(rd_data0), 64'(exp_b[i]));
        end
        tick();
        check("rvalid_pulse", 64'(rvalid0), 64'd0);
        check("rdata_hold", 64'(rd_data0), 64'hDE);
        check("ptr_after4", 64'(ptr0), 64'd4);
        byte_op(1'b1, 10'd2, 1'b0, 1'b1, 8'h0);
        check("load_re_data", 64'(rd_data0), 64'hAD);
        check("load_re_ptr", 64'(ptr0), 64'd3);

        // Channel 1 byte writes wrapping from 1023 to 0.
        mem_chan = 1'b1;
        byte_op(1'b1, 10'd1023, 1'b0, 1'b0, 8'h0);
        byte_op(1'b0, 10'd0, 1'b1, 1'b0, 8'h11);
        byte_op(1'b0, 10'd0, 1'b1, 1'b0, 8'h22);
        byte_op(1'b0, 10'd0, 1'b1, 1'b0, 8'h33);
        check("wrap_ptr", 64'(ptr0), 64'd2);

        for (int i = 11; i <= 13; i++) begin
            bus_xfer(vtab[i].we, vtab[i].addr, vtab[i].data, vtab[i].strb, rd, lat);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
            check($sformatf("vec%0d_bdata", i), 64'(rd), 64'(vtab[i].exp));
        end

        // Backpressure: response held while bready is low.
        bif.avalid = 1'b1; bif.awe = 1'b0; bif.aaddr = 9'd0; bif.bready = 1'b0;
        tick();
        bif.avalid = 1'b0;
        n = 1;
        while (!bif.bvalid && n < 20) begin
            tick();
            n++;
        end
        check("bp_lat", 64'(n), 64'd2);
        bif.avalid = 1'b1; bif.aaddr = 9'd1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d", k), {bif.bvalid, bif.aready, 30'd0, bif.bdata},
                  {1'b1, 1'b0, 30'd0, 32'hDEAD_BEEF});
            tick();
        end
        bif.bready = 1'b1;
        tick();
        check("bp_after_hs", {62'd0, bif.bvalid, bif.aready}, 64'b01);
        tick();
        bif.avalid = 1'b0;
        check("bp_second_accept", 64'(bif.aready), 64'd0);
        n = 1;
        while (!bif.bvalid && n < 20) begin
            tick();
            n++;
        end
        check("bp_second_lat", 64'(n), 64'd2);
        check("bp_second_data", 64'(bif.bdata), 64'h00BB_00DD);
        tick();

        // Same-cycle bus write and byte write.
        coll_write(9'd0, 32'hFFFF_FFFF, 4'hF, 10'd0, 8'h42, rd);
        check("coll_resp_old", 64'(rd), 64'hDEAD_BEEF);
`ifdef USB_BUF_MEM_COLLISION_CNT_EN
        check("coll_cnt_one", 64'(coll_cnt0), 64'd1);
`endif
        coll_write(9'd1, 32'hA1B2_C3D4, 4'hE, 10'd4, 8'h77, rd);
        check("coll2_resp_old", 64'(rd), 64'h00BB_00DD);
        bus_xfer(1'b0, 9'd0, 32'h0, 4'h0, rd, lat);
        check("coll_same_byte", 64'(rd), 64'hFFFF_FF42);
        bus_xfer(1'b0, 9'd1, 32'h0, 4'h0, rd, lat);
        check("coll_diff_byte", 64'(rd), 64'hA1B2_C377);
        check("ptr_after_coll", 64'(ptr0), 64'd5);
`ifdef USB_BUF_MEM_COLLISION_CNT_EN
        check("coll_cnt_hold", 64'(coll_cnt0), 64'd1);
        bus_xfer(1'b1, 9'd511, 32'h1234_5678, 4'hF, rd, lat);
        check("coll_cnt_clear", 64'(coll_cnt0), 64'd0);
`endif

        // 64-bit, RD_PIPE=1 instance.
        bus_xfer_p(1'b1, 8'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, rdp, lat);
        check("p_wr_lat", 64'(lat), 64'd3);
        bus_xfer_p(1'b0, 8'd3, 64'h0, 8'h00, rdp, lat);
        check("p_rd_lat", 64'(lat), 64'd3);
        check("p_rd_data", rdp, 64'h0123_4567_89AB_CDEF);
        check("p_ptr", 64'(ptr1), 64'd5);

        // Reset asserted in the ACC cycle.
        bifp.avalid = 1'b1; bifp.awe = 1'b0; bifp.aaddr = 8'd3; bifp.bready = 1'b1;
        tick();
        bifp.avalid = 1'b0;
        check("p_acc_aready", 64'(bifp.aready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("p_rst_bvalid", 64'(bifp.bvalid), 64'd0);
        check("p_rst_aready", 64'(bifp.aready), 64'd1);
        check("p_rst_ptr", 64'(ptr1), 64'd0);
        check("rst_ptr_dflt", 64'(ptr0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("p_no_resp", 64'(bifp.bvalid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
